z80_input_cond: RTL
===================

# z80_input_cond

Input conditioning stage between the input pad ring and the `cpu_z80` core. Takes the raw pad outputs `INT_I`, `NMI_I` and `WAIT_I`, synchronises them to `CLK`, and applies per-signal conditioning before they reach the core:
- stretches the core reset;
- deglitches the maskable interrupt;
- turns NMI into a latched, acknowledge-cleared request;
- guards WAIT with a timeout watchdog so a stuck peripheral cannot freeze the bus.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth per input (legal ≥ 2).
- `RST_HOLD`, default 16: cycles `RESET_C` stays high after `RESET` deasserts (legal 1..255).
- `INT_FILT`, default 3: consecutive stable cycles required before `INT_C` follows a change (legal 1..15).
- `WAIT_MAX`, default 255: maximum consecutive cycles `WAIT_C` may stay high (legal 1..65535).

Ports:
- `CLK`  in  1  single clock for the whole block.
- `RESET`  in  1  synchronous, active-high reset.
- `INT_I`  in  1  raw interrupt request from pad, active-high, asynchronous.
- `NMI_I`  in  1  raw non-maskable interrupt from pad, active-high, asynchronous.
- `WAIT_I`  in  1  raw wait request from pad, active-high, asynchronous.
- `NMI_ACK`  in  1  one-cycle pulse from the core when it accepts the NMI.
- `RESET_C`  out  1  stretched reset to the core.
- `INT_C`  out  1  filtered interrupt level to the core.
- `NMI_C`  out  1  pending NMI request to the core.
- `WAIT_C`  out  1  guarded wait to the core.
- `WAIT_TO`  out  1  sticky wait-timeout flag.

## Operation
- **Synchronisers.** `SYNC_STAGES` flops each for `INT_I`, `NMI_I` and `WAIT_I`; their outputs are `int_s`, `nmi_s` and `wait_s`. All flops clear to 0 on `RESET`.
- **Reset stretcher.**
  - While `RESET` is high: `RESET_C` is 1 and the hold counter is 0.
  - Each cycle `RESET` is low, the counter increments. When it reaches `RST_HOLD`, `RESET_C` goes to 0 and the counter saturates.
  - `RESET` reasserting at any point restarts the sequence.
- **Quiet during reset.** While `RESET_C` is 1, the following are forced to 0: `INT_C`, `NMI_C`, `WAIT_C`, the filter counter, the wait counter and the NMI edge history.
- **NMI.**
  - The edge history register `nmi_d` tracks `nmi_s` while `RESET_C` is 0. Because it is held at 0 during `RESET_C`, an NMI line that is already high when `RESET_C` falls produces a single edge on the first cycle after release.
  - A rising edge (`nmi_s & ~nmi_d`) sets `nmi_pend`. `NMI_ACK` clears it. If an edge and an ack arrive in the same cycle, the set wins.
  - `NMI_C = nmi_pend` (registered).
- **INT.**
  - While `int_s` equals `INT_C`, the filter counter is held at 0.
  - While they differ, the counter increments. When it reaches `INT_FILT`, `INT_C` takes the value of `int_s` and the counter clears.
  - Any cycle in which `int_s` matches `INT_C` again resets the counter, so glitches shorter than `INT_FILT` cycles are rejected.
- **WAIT state machine.**
  - `W_IDLE`: `WAIT_C` is 0. Go to `W_HOLD` when `wait_s` is 1.
  - `W_HOLD`: `WAIT_C` is 1 and the wait counter increments each cycle. Go to `W_IDLE` when `wait_s` is 0. Go to `W_TIMEOUT` when the counter reaches `WAIT_MAX`; this sets `WAIT_TO`.
  - `W_TIMEOUT`: `WAIT_C` is 0 (bus forced to proceed). Go to `W_IDLE` only once `wait_s` is 0.
  - The wait counter clears on every entry to `W_IDLE`. It is 16 bits wide and never wraps.
  - `WAIT_TO` is cleared only by `RESET`.
- **Reset values.** After `RESET`: `RESET_C=1`, `INT_C=0`, `NMI_C=0`, `WAIT_C=0`, `WAIT_TO=0`, FSM in `W_IDLE`.
- **Reset mid-operation.** Aborts any pending NMI and any active wait, and clears `WAIT_TO`.

## Timing
In this section, "edge 0" is the first `CLK` edge that samples the input at its new value.
- `RESET_C` rises at the edge that samples `RESET` high. It falls at the `RST_HOLD`-th consecutive edge sampling `RESET` low.
- `nmi_s` and `wait_s` are valid after edge `SYNC_STAGES-1`.
- `NMI_C` is high after edge `SYNC_STAGES` (latency `SYNC_STAGES+1` edges). It is low after the edge that samples `NMI_ACK` high.
- `WAIT_C` is high after edge `SYNC_STAGES`. It is low after edge `SYNC_STAGES` of the deassertion, or after `WAIT_MAX` cycles high.
- `INT_C` follows after edge `SYNC_STAGES-1+INT_FILT`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use default parameters.
1. **Reset stretch.** Hold `RESET` 5 cycles, then release → `RESET_C` stays 1 for exactly 16 cycles after release. All other outputs are 0 throughout.
2. **NMI edge and ack.**
   - Pulse `NMI_I` high for 1 cycle → `NMI_C=1` after 3 edges and stays high while `NMI_I` is low.
   - Pulse `NMI_ACK` → `NMI_C=0` the next cycle.
   - Assert `NMI_ACK` in the same cycle as a new edge → `NMI_C` remains 1.
3. **INT filter.**
   - Pulse `INT_I` high for 2 cycles → `INT_C` stays 0.
   - Hold `INT_I` high for 10 cycles → `INT_C=1` after edge 4.
   - Drop `INT_I` for 1 cycle → `INT_C` stays 1.
4. **WAIT timeout.**
   - Hold `WAIT_I` high for 300 cycles → `WAIT_C` is high for exactly 255 cycles, then 0, with `WAIT_TO=1`.
   - Drop `WAIT_I`, then reassert it → `WAIT_C` high again and `WAIT_TO` still 1.
5. **NMI held through reset.** Hold `NMI_I` high across the whole reset → exactly one `NMI_C` assertion after `RESET_C` falls.
6. **Reset mid-wait.** Assert `RESET` during `W_HOLD` with `NMI_C=1` → next cycle `WAIT_C=0`, `NMI_C=0`, `WAIT_TO=0`, `RESET_C=1`.

Source files
------------

// File: rtl/z80_input_cond.sv
// Input conditioning between the pad ring and the Z80 core: synchronises INT/NMI/WAIT,
// stretches reset, deglitches INT, latches NMI until acknowledged and guards WAIT with a timeout.
module z80_input_cond #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_HOLD    = 16,
  parameter int unsigned INT_FILT    = 3,
  parameter int unsigned WAIT_MAX    = 255
) (
  input  logic CLK,
  input  logic RESET,
  input  logic INT_I,
  input  logic NMI_I,
  input  logic WAIT_I,
  input  logic NMI_ACK,
  output logic RESET_C,
  output logic INT_C,
  output logic NMI_C,
  output logic WAIT_C,
  output logic WAIT_TO
);

  localparam int unsigned RST_CW  = 8;
  localparam int unsigned FILT_CW = 4;
  localparam int unsigned WAIT_CW = 16;

  localparam logic [RST_CW-1:0]  RST_HOLD_V = RST_CW'(RST_HOLD);
  localparam logic [FILT_CW-1:0] INT_FILT_V = FILT_CW'(INT_FILT);
  localparam logic [WAIT_CW-1:0] WAIT_MAX_V = WAIT_CW'(WAIT_MAX);

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HOLD    = 2'd1,
    W_TIMEOUT = 2'd2
  } wait_state_e;

  // Synchronisers
  logic [SYNC_STAGES-1:0] int_sync_q;
  logic [SYNC_STAGES-1:0] nmi_sync_q;
  logic [SYNC_STAGES-1:0] wait_sync_q;
  logic                   int_s;
  logic                   nmi_s;
  logic                   wait_s;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      int_sync_q  <= '0;
      nmi_sync_q  <= '0;
      wait_sync_q <= '0;
    end else begin
      int_sync_q  <= {int_sync_q[SYNC_STAGES-2:0], INT_I};
      nmi_sync_q  <= {nmi_sync_q[SYNC_STAGES-2:0], NMI_I};
      wait_sync_q <= {wait_sync_q[SYNC_STAGES-2:0], WAIT_I};
    end
  end

  assign int_s  = int_sync_q[SYNC_STAGES-1];
  assign nmi_s  = nmi_sync_q[SYNC_STAGES-1];
  assign wait_s = wait_sync_q[SYNC_STAGES-1];

  // Reset stretcher: counter saturates at RST_HOLD, RESET_C drops on the edge it gets there
  logic [RST_CW-1:0] rst_cnt_q;
  logic [RST_CW-1:0] rst_cnt_d;
  logic              reset_c_q;
  logic              reset_c_d;

  always_comb begin
    rst_cnt_d = rst_cnt_q;
    reset_c_d = reset_c_q;
    if (RESET) begin
      rst_cnt_d = '0;
      reset_c_d = 1'b1;
    end else if (rst_cnt_q != RST_HOLD_V) begin
      rst_cnt_d = rst_cnt_q + RST_CW'(1);
      reset_c_d = (rst_cnt_d != RST_HOLD_V);
    end else begin
      reset_c_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rst_cnt_q <= '0;
      reset_c_q <= 1'b1;
    end else begin
      rst_cnt_q <= rst_cnt_d;
      reset_c_q <= reset_c_d;
    end
  end

  // Everything downstream is held idle while the core is still in reset
  logic quiet;
  assign quiet = RESET | reset_c_q;

  // INT deglitch filter
  logic [FILT_CW-1:0] filt_cnt_q;
  logic [FILT_CW-1:0] filt_cnt_d;
  logic               int_c_q;
  logic               int_c_d;

  always_comb begin
    filt_cnt_d = filt_cnt_q;
    int_c_d    = int_c_q;
    if (quiet) begin
      filt_cnt_d = '0;
      int_c_d    = 1'b0;
    end else if (int_s == int_c_q) begin
      filt_cnt_d = '0;
    end else if ((filt_cnt_q + FILT_CW'(1)) == INT_FILT_V) begin
      filt_cnt_d = '0;
      int_c_d    = int_s;
    end else begin
      filt_cnt_d = filt_cnt_q + FILT_CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      filt_cnt_q <= '0;
      int_c_q    <= 1'b0;
    end else begin
      filt_cnt_q <= filt_cnt_d;
      int_c_q    <= int_c_d;
    end
  end

  // NMI edge latch; a fresh edge beats a simultaneous acknowledge
  logic nmi_hist_q;
  logic nmi_hist_d;
  logic nmi_pend_q;
  logic nmi_pend_d;

  always_comb begin
    nmi_hist_d = nmi_hist_q;
    nmi_pend_d = nmi_pend_q;
    if (quiet) begin
      nmi_hist_d = 1'b0;
      nmi_pend_d = 1'b0;
    end else begin
      nmi_hist_d = nmi_s;
      if (nmi_s && !nmi_hist_q) begin
        nmi_pend_d = 1'b1;
      end else if (NMI_ACK) begin
        nmi_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      nmi_hist_q <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_hist_q <= nmi_hist_d;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  // WAIT watchdog FSM; the counter holds the number of cycles spent in W_HOLD
  wait_state_e        state_q;
  wait_state_e        state_d;
  logic [WAIT_CW-1:0] wait_cnt_q;
  logic [WAIT_CW-1:0] wait_cnt_d;
  logic               wait_c_q;
  logic               wait_c_d;
  logic               wait_to_q;
  logic               wait_to_d;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wait_to_d  = wait_to_q;
    wait_c_d   = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (wait_s) begin
          state_d    = W_HOLD;
          wait_cnt_d = WAIT_CW'(1);
        end
      end
      W_HOLD: begin
        if (!wait_s) begin
          state_d    = W_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_MAX_V) begin
          state_d   = W_TIMEOUT;
          wait_to_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CW'(1);
        end
      end
      W_TIMEOUT: begin
        if (!wait_s) begin
          state_d    = W_IDLE;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = W_IDLE;
        wait_cnt_d = '0;
      end
    endcase
    if (quiet) begin
      state_d    = W_IDLE;
      wait_cnt_d = '0;
    end
    if (RESET) begin
      wait_to_d = 1'b0;
    end
    wait_c_d = (state_d == W_HOLD);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= W_IDLE;
      wait_cnt_q <= '0;
      wait_c_q   <= 1'b0;
      wait_to_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wait_c_q   <= wait_c_d;
      wait_to_q  <= wait_to_d;
    end
  end

  assign RESET_C = reset_c_q;
  assign INT_C   = int_c_q;
  assign NMI_C   = nmi_pend_q;
  assign WAIT_C  = wait_c_q;
  assign WAIT_TO = wait_to_q;

endmodule
